// File: rtl/apb_slv_router.sv
// APB segment router: one master port fanned out to NSLV slaves through a run-time address map,
// with unmapped-address errors, per-access timeout abort and saturating error statistics.
package apb_slv_router_pkg;
   typedef struct packed {
      logic [63:0] addr_start;
      logic [63:0] addr_end;
   } mapinfo_type;

   typedef struct packed {
      logic [31:0] paddr;
      logic [2:0]  pprot;
      logic        pselx;
      logic        penable;
      logic        pwrite;
      logic [31:0] pwdata;
      logic [3:0]  pstrb;
   } apb_in_type;

   typedef struct packed {
      logic        pready;
      logic [31:0] prdata;
      logic        pslverr;
   } apb_out_type;
endpackage

module apb_slv_router
   import apb_slv_router_pkg::*;
#(
   parameter int NSLV    = 8,
   parameter int TIMEOUT = 256,
   parameter int CNTW    = 16
) (
   input  logic            i_clk,
   input  logic            i_nrst,
   input  mapinfo_type     i_mapinfo [NSLV],
   input  apb_in_type      i_mapb,
   output apb_out_type     o_mapb,
   output apb_in_type      o_sapb [NSLV],
   input  apb_out_type     i_sapb [NSLV],
   output logic            o_err_valid,
   output logic [31:0]     o_err_addr,
   output logic [CNTW-1:0] o_err_cnt
);
   localparam int SELW = (NSLV > 1) ? $clog2(NSLV) : 1;
   localparam int TCW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TCW-1:0] TC_LAST = TCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [NSLV-1:0]   w_hit;
   logic [SELW-1:0]   w_sel;
   logic              w_req;
   logic              w_slv_ready;
   logic              w_slv_err;
   logic              w_timeout;
   logic              w_err_log;

   logic [31:0]       r_paddr;
   logic [2:0]        r_pprot;
   logic              r_pwrite;
   logic [31:0]       r_pwdata;
   logic [3:0]        r_pstrb;
   logic [SELW-1:0]   r_sel;
   logic              r_hit;
   logic [TCW-1:0]    r_tcnt;
   logic [31:0]       r_prdata;
   logic              r_err;
   logic [31:0]       r_err_addr;
   logic [CNTW-1:0]   r_err_cnt;

   // Window test on the zero-extended address; an empty window (start==end) can never hit.
   genvar gi;
   generate
      for (gi = 0; gi < NSLV; gi++) begin : g_hit
         assign w_hit[gi] = ({32'd0, i_mapb.paddr} >= i_mapinfo[gi].addr_start) &&
                            ({32'd0, i_mapb.paddr} <  i_mapinfo[gi].addr_end);
      end
   endgenerate

   always_comb begin
      w_sel = '0;
      for (int i = NSLV - 1; i >= 0; i--) begin
         if (w_hit[i]) w_sel = SELW'(i);
      end
   end

   assign w_req       = i_mapb.pselx & ~i_mapb.penable;
   assign w_slv_ready = i_sapb[r_sel].pready;
   assign w_slv_err   = i_sapb[r_sel].pslverr;
   assign w_timeout   = (TIMEOUT != 0) && (r_tcnt == TC_LAST) && !w_slv_ready;
   assign w_err_log   = ((r_state == S_SETUP) && !r_hit) ||
                        ((r_state == S_ACCESS) && ((w_slv_ready && w_slv_err) || w_timeout));

   always_ff @(posedge i_clk) begin
      if (!i_nrst) r_state <= S_IDLE;
      else         r_state <= w_state_next;
   end

   // Unmapped requests still pass through SETUP so the error reply has the same shape as a slave reply.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:   if (w_req) w_state_next = S_SETUP;
         S_SETUP:  w_state_next = r_hit ? S_ACCESS : S_RESP;
         S_ACCESS: if (w_slv_ready || w_timeout) w_state_next = S_RESP;
         S_RESP:   w_state_next = S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
         r_paddr    <= '0;
         r_pprot    <= '0;
         r_pwrite   <= 1'b0;
         r_pwdata   <= '0;
         r_pstrb    <= '0;
         r_sel      <= '0;
         r_hit      <= 1'b0;
         r_tcnt     <= '0;
         r_prdata   <= '0;
         r_err      <= 1'b0;
         r_err_addr <= '0;
         r_err_cnt  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  r_paddr  <= i_mapb.paddr;
                  r_pprot  <= i_mapb.pprot;
                  r_pwrite <= i_mapb.pwrite;
                  r_pwdata <= i_mapb.pwdata;
                  r_pstrb  <= i_mapb.pstrb;
                  r_sel    <= w_sel;
                  r_hit    <= |w_hit;
                  r_prdata <= '0;
                  r_err    <= 1'b0;
               end
            end
            S_SETUP: begin
               r_tcnt <= '0;
               if (!r_hit) r_err <= 1'b1;
            end
            S_ACCESS: begin
               r_tcnt <= r_tcnt + 1'b1;
               if (w_slv_ready) begin
                  r_err    <= w_slv_err;
                  r_prdata <= (!r_pwrite && !w_slv_err) ? i_sapb[r_sel].prdata : 32'd0;
               end else if (w_timeout) begin
                  r_err    <= 1'b1;
                  r_prdata <= '0;
               end
            end
            default: ;
         endcase
         if (w_err_log) begin
            r_err_addr <= r_paddr;
            if (r_err_cnt != {CNTW{1'b1}}) r_err_cnt <= r_err_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      o_mapb      = '0;
      o_err_valid = 1'b0;
      if (r_state == S_RESP) begin
         o_mapb.pready  = 1'b1;
         o_mapb.prdata  = r_prdata;
         o_mapb.pslverr = r_err;
         o_err_valid    = r_err;
      end
   end

   assign o_err_addr = r_err_addr;
   assign o_err_cnt  = r_err_cnt;

   generate
      for (gi = 0; gi < NSLV; gi++) begin : g_sapb
         always_comb begin
            o_sapb[gi] = '0;
            if (((r_state == S_SETUP) || (r_state == S_ACCESS)) && r_hit && (r_sel == SELW'(gi))) begin
               o_sapb[gi].paddr   = r_paddr;
               o_sapb[gi].pprot   = r_pprot;
               o_sapb[gi].pselx   = 1'b1;
               o_sapb[gi].penable = (r_state == S_ACCESS);
               o_sapb[gi].pwrite  = r_pwrite;
               o_sapb[gi].pwdata  = r_pwdata;
               o_sapb[gi].pstrb   = r_pstrb;
            end
         end
      end
   endgenerate
endmodule

// File: tb/tb_apb_slv_router.sv
// Bench for apb_slv_router: directed master transfers, behavioural slaves, queue-based response checker.
module tb_apb_slv_router;
   import apb_slv_router_pkg::*;

   localparam int NS = 8;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      logic [31:0] eaddr;
      int          ecnt;
      int          start;
   } exp_t;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   mapinfo_type map [NS];
   apb_in_type  mapb;
   apb_out_type mapb_o;
   apb_in_type  sapb_o [NS];
   apb_out_type sapb_i [NS];
   logic        err_valid;
   logic [31:0] err_addr;
   logic [1:0]  err_cnt;

   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   exp_t        sb_q[$];
   int          exp_cnt = 0;

   int          waitst [NS];
   logic [31:0] rdat [NS];
   logic        serr [NS];
   int          wcnt [NS];
   int          setup_cyc [NS];
   int          acc_cyc [NS];
   int          acc_n [NS];
   int          psel_n [NS];
   logic [31:0] wdata_seen [NS];
   logic        wr_seen [NS];

   apb_slv_router #(.NSLV(NS), .TIMEOUT(4), .CNTW(2)) dut (
      .i_clk(clk), .i_nrst(nrst), .i_mapinfo(map), .i_mapb(mapb), .o_mapb(mapb_o),
      .o_sapb(sapb_o), .i_sapb(sapb_i), .o_err_valid(err_valid), .o_err_addr(err_addr),
      .o_err_cnt(err_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   task automatic clear_mon();
      for (int i = 0; i < NS; i++) begin
         setup_cyc[i] = -1; acc_cyc[i] = -1; acc_n[i] = 0; psel_n[i] = 0;
         wdata_seen[i] = '0; wr_seen[i] = 1'b0;
      end
   endtask

   // Behavioural slaves: each inserts waitst[i] wait states, then returns rdat/serr.
   initial begin
      for (int i = 0; i < NS; i++) begin
         sapb_i[i] = '0; waitst[i] = 0; rdat[i] = '0; serr[i] = 1'b0; wcnt[i] = 0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < NS; i++) begin
            sapb_i[i] = '0;
            if (sapb_o[i].pselx) psel_n[i]++;
            if (sapb_o[i].pselx && !sapb_o[i].penable && setup_cyc[i] < 0) setup_cyc[i] = cyc;
            if (sapb_o[i].pselx && sapb_o[i].penable) begin
               acc_n[i]++;
               if (acc_cyc[i] < 0) begin
                  acc_cyc[i] = cyc; wdata_seen[i] = sapb_o[i].pwdata; wr_seen[i] = sapb_o[i].pwrite;
               end
               if (wcnt[i] >= waitst[i]) begin
                  sapb_i[i].pready = 1'b1; sapb_i[i].prdata = rdat[i]; sapb_i[i].pslverr = serr[i];
               end
               wcnt[i]++;
            end else begin
               wcnt[i] = 0;
            end
         end
      end
   end

   // Only one slave port may ever be selected.
   always @(negedge clk) begin
      int n;
      n = 0;
      for (int i = 0; i < NS; i++) if (sapb_o[i].pselx) n++;
      if (n != 0) check("onehot_psel", 64'(n), 64'd1);
   end

   // Response checker: pops one expectation per master pready.
   always @(negedge clk) begin
      exp_t e;
      if (nrst && mapb_o.pready) begin
         if (sb_q.size() == 0) begin
            check("unexpected_pready", 64'(mapb_o.pready), 64'd0);
         end else begin
            e = sb_q.pop_front();
            $display("txn done cyc=%0d prdata=0x%08h pslverr=%0d err_cnt=%0d",
                     cyc, mapb_o.prdata, mapb_o.pslverr, err_cnt);
            check("prdata", 64'(mapb_o.prdata), 64'(e.rdata));
            check("pslverr", 64'(mapb_o.pslverr), 64'(e.err));
            check("err_valid", 64'(err_valid), 64'(e.err));
            if (e.lat >= 0) check("latency", 64'(cyc - e.start), 64'(e.lat));
            if (e.err) begin
               check("err_addr", 64'(err_addr), 64'(e.eaddr));
               check("err_cnt", 64'(err_cnt), 64'(e.ecnt));
            end
         end
      end
   end

   task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input int lat, output int c0);
      exp_t e;
      bit   got;
      clear_mon();
      @(negedge clk);
      mapb = '0;
      mapb.paddr = addr; mapb.pwrite = wr; mapb.pwdata = wd; mapb.pstrb = 4'hF; mapb.pselx = 1'b1;
      c0 = cyc;
      if (exp_err) exp_cnt = (exp_cnt == 3) ? 3 : exp_cnt + 1;
      e.rdata = exp_rd; e.err = exp_err; e.lat = lat; e.eaddr = addr; e.ecnt = exp_cnt; e.start = c0;
      sb_q.push_back(e);
      $display("txn start cyc=%0d addr=0x%08h write=%0d wdata=0x%08h", c0, addr, wr, wd);
      @(negedge clk);
      mapb.penable = 1'b1;
      got = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (mapb_o.pready) begin got = 1; break; end
      end
      if (!got) check("pready_timeout", 64'd0, 64'd1);
      mapb = '0;
   endtask

   initial begin
      int c0;
      int tot;
      bit nz;
      mapb = '0;
      for (int i = 0; i < NS; i++) map[i] = '0;
      map[0] = '{addr_start: 64'h10000, addr_end: 64'h11000};
      map[7] = '{addr_start: 64'hFF000, addr_end: 64'h100000};
      map[1] = '{addr_start: 64'h12000, addr_end: 64'h13000};
      map[2] = '{addr_start: 64'h12000, addr_end: 64'h13000};
      clear_mon();
      repeat (3) @(negedge clk);
      check("rst_mapb", 64'(mapb_o), 64'd0);
      check("rst_err_valid", 64'(err_valid), 64'd0);
      check("rst_err_addr", 64'(err_addr), 64'd0);
      check("rst_err_cnt", 64'(err_cnt), 64'd0);
      nz = 0;
      for (int i = 0; i < NS; i++) if (sapb_o[i] != '0) nz = 1;
      check("rst_sapb_zero", 64'(nz), 64'd0);
      nrst = 1'b1;

      xfer(32'h10004, 1'b1, 32'hA5A5A5A5, 32'h0, 1'b0, 3, c0);
      check("s0_setup_cycle", 64'(setup_cyc[0] - c0), 64'd1);
      check("s0_access_cycle", 64'(acc_cyc[0] - c0), 64'd2);
      check("s0_pwdata", 64'(wdata_seen[0]), 64'hA5A5A5A5);
      check("s0_pwrite", 64'(wr_seen[0]), 64'd1);

      waitst[7] = 3; rdat[7] = 32'h12345678;
      xfer(32'hFF000, 1'b0, 32'h0, 32'h12345678, 1'b0, 6, c0);

      waitst[0] = 1; rdat[0] = 32'hBEEF0001;
      xfer(32'h10FFC, 1'b0, 32'h0, 32'hBEEF0001, 1'b0, 4, c0);

      xfer(32'h20000, 1'b0, 32'h0, 32'h0, 1'b1, 2, c0);
      tot = 0;
      for (int i = 0; i < NS; i++) tot += psel_n[i];
      check("unmapped_no_psel", 64'(tot), 64'd0);

      xfer(32'h11000, 1'b1, 32'h55, 32'h0, 1'b1, 2, c0);

      waitst[0] = 100;
      xfer(32'h10008, 1'b0, 32'h0, 32'h0, 1'b1, -1, c0);
      check("timeout_access_cycles", 64'(acc_n[0]), 64'd4);

      rdat[1] = 32'h11111111; rdat[2] = 32'h22222222;
      xfer(32'h12010, 1'b0, 32'h0, 32'h11111111, 1'b0, 3, c0);
      check("overlap_s2_idle", 64'(psel_n[2]), 64'd0);
      check("overlap_s1_used", 64'(psel_n[1]), 64'd2);

      serr[1] = 1'b1;
      xfer(32'h12020, 1'b0, 32'h0, 32'h0, 1'b1, 3, c0);
      serr[1] = 1'b0;
      xfer(32'h00000000, 1'b0, 32'h0, 32'h0, 1'b1, 2, c0);

      // Reset while s0 is in ACCESS: transfer is discarded without a response.
      clear_mon();
      @(negedge clk);
      mapb = '0; mapb.paddr = 32'h10010; mapb.pselx = 1'b1;
      @(negedge clk);
      mapb.penable = 1'b1;
      @(negedge clk);
      check("rst_mid_in_access", 64'(sapb_o[0].pselx & sapb_o[0].penable), 64'd1);
      nrst = 1'b0;
      @(negedge clk);
      check("rst_mid_mapb", 64'(mapb_o), 64'd0);
      check("rst_mid_err_cnt", 64'(err_cnt), 64'd0);
      check("rst_mid_err_addr", 64'(err_addr), 64'd0);
      nz = 0;
      for (int i = 0; i < NS; i++) if (sapb_o[i] != '0) nz = 1;
      check("rst_mid_sapb_zero", 64'(nz), 64'd0);
      nrst = 1'b1; mapb = '0; exp_cnt = 0;

      waitst[0] = 0; rdat[0] = 32'hCAFEF00D;
      xfer(32'h10010, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, 3, c0);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
